// File: rtl/controlador_jogadas_inicial_if.sv
// Bus between the initial-move sequencer and its environment:
// start request, generator squares/strobe, and the square delivery handshake.
interface controlador_jogadas_inicial_if;
  logic       iniciar;
  logic [2:0] coluna1_in;
  logic [2:0] linha1_in;
  logic [2:0] coluna2_in;
  logic [2:0] linha2_in;
  logic [2:0] coluna3_in;
  logic [2:0] linha3_in;
  logic       ack;
  logic       novaJogada;
  logic [2:0] coluna;
  logic [2:0] linha;
  logic [1:0] indice;
  logic       valido;
  logic       pronto;
  logic       erro;
  logic [3:0] tentativas;

  // Sequencer side
  modport master (
    input  iniciar, coluna1_in, linha1_in, coluna2_in, linha2_in,
           coluna3_in, linha3_in, ack,
    output novaJogada, coluna, linha, indice, valido, pronto, erro, tentativas
  );

  // Environment side (generator, game datapath, start logic)
  modport slave (
    output iniciar, coluna1_in, linha1_in, coluna2_in, linha2_in,
           coluna3_in, linha3_in, ack,
    input  novaJogada, coluna, linha, indice, valido, pronto, erro, tentativas
  );
endinterface

// File: rtl/controlador_jogadas_inicial.sv
// Initial-move sequencer: strobes the generator, waits for it to settle,
// captures three squares, retries draws with coinciding squares, and
// delivers the accepted squares one by one over a valid/ack handshake.
module controlador_jogadas_inicial #(
  parameter int ESPERA_CICLOS  = 2,
  parameter int MAX_TENTATIVAS = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  controlador_jogadas_inicial_if.master   bus
);

  typedef enum logic [2:0] {
    OCIOSO, GERA, ESPERA, CAPTURA, VERIFICA, APRESENTA, FIM, ERRO
  } estado_t;

  localparam logic [3:0] ESPERA_FIM = 4'(ESPERA_CICLOS - 1);
  localparam logic [3:0] TENT_MAX   = 4'(MAX_TENTATIVAS);

  estado_t    state_reg, state_next;
  logic [3:0] espera_reg, espera_next;
  logic [1:0] indice_reg, indice_next;
  logic [3:0] tentativas_reg, tentativas_next;
  logic       pronto_reg, pronto_next;
  logic       erro_reg, erro_next;
  logic       novajogada_reg;
  logic [5:0] sq_reg [3];
  logic [5:0] sq_in  [3];
  logic [5:0] sq_sel;
  logic       captura;
  logic       repetido;
  logic       valido;

  // Squares are {coluna, linha}
  assign sq_in[0] = {bus.coluna1_in, bus.linha1_in};
  assign sq_in[1] = {bus.coluna2_in, bus.linha2_in};
  assign sq_in[2] = {bus.coluna3_in, bus.linha3_in};

  // A draw is rejected when any two captured squares coincide
  assign repetido = (sq_reg[0] == sq_reg[1]) || (sq_reg[0] == sq_reg[2]) ||
                    (sq_reg[1] == sq_reg[2]);

  // State, counters and held status flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= OCIOSO;
      espera_reg     <= 4'd0;
      indice_reg     <= 2'd0;
      tentativas_reg <= 4'd0;
      pronto_reg     <= 1'b0;
      erro_reg       <= 1'b0;
      novajogada_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      espera_reg     <= espera_next;
      indice_reg     <= indice_next;
      tentativas_reg <= tentativas_next;
      pronto_reg     <= pronto_next;
      erro_reg       <= erro_next;
      novajogada_reg <= (state_next == GERA);
    end
  end

  // Square capture; only the registered copy is compared and presented
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) sq_reg[i] <= 6'd0;
    end else if (captura) begin
      for (int i = 0; i < 3; i++) sq_reg[i] <= sq_in[i];
    end
  end

  // Next-state logic; pronto/erro are set on the transition so they are
  // already high during FIM/ERRO and then held through OCIOSO
  always_comb begin
    state_next      = state_reg;
    espera_next     = espera_reg;
    indice_next     = indice_reg;
    tentativas_next = tentativas_reg;
    pronto_next     = pronto_reg;
    erro_next       = erro_reg;
    captura         = 1'b0;
    case (state_reg)
      OCIOSO: begin
        if (bus.iniciar) begin
          state_next      = GERA;
          pronto_next     = 1'b0;
          erro_next       = 1'b0;
          tentativas_next = 4'd0;
        end
      end
      GERA: begin
        state_next      = ESPERA;
        espera_next     = 4'd0;
        tentativas_next = (tentativas_reg == 4'd15) ? 4'd15 : tentativas_reg + 4'd1;
      end
      ESPERA: begin
        if (espera_reg == ESPERA_FIM) state_next = CAPTURA;
        else                          espera_next = espera_reg + 4'd1;
      end
      CAPTURA: begin
        captura    = 1'b1;
        state_next = VERIFICA;
      end
      VERIFICA: begin
        if (repetido) begin
          if (tentativas_reg == TENT_MAX) begin
            state_next = ERRO;
            erro_next  = 1'b1;
          end else begin
            state_next = GERA;
          end
        end else begin
          indice_next = 2'd0;
          state_next  = APRESENTA;
        end
      end
      APRESENTA: begin
        if (bus.ack) begin
          if (indice_reg == 2'd2) begin
            state_next  = FIM;
            pronto_next = 1'b1;
            indice_next = 2'd0;
          end else begin
            indice_next = indice_reg + 2'd1;
          end
        end
      end
      FIM:     state_next = OCIOSO;
      ERRO:    state_next = OCIOSO;
      default: state_next = OCIOSO;
    endcase
  end

  // Presented square selection
  always_comb begin
    sq_sel = 6'd0;
    case (indice_reg)
      2'd0:    sq_sel = sq_reg[0];
      2'd1:    sq_sel = sq_reg[1];
      2'd2:    sq_sel = sq_reg[2];
      default: sq_sel = 6'd0;
    endcase
  end

  assign valido         = (state_reg == APRESENTA);
  assign bus.valido     = valido;
  assign bus.coluna     = valido ? sq_sel[5:3] : 3'd0;
  assign bus.linha      = valido ? sq_sel[2:0] : 3'd0;
  assign bus.indice     = valido ? indice_reg  : 2'd0;
  assign bus.novaJogada = novajogada_reg;
  assign bus.pronto     = pronto_reg;
  assign bus.erro       = erro_reg;
  assign bus.tentativas = tentativas_reg;

endmodule

// File: doc/controlador_jogadas_inicial.md
Name: controlador_jogadas_inicial

Overview:
- Sequencer for the initial-move generator.
- On `iniciar`, it pulses `novaJogada` and waits for the generator outputs to settle.
- It captures the three squares and rejects any draw where two squares coincide; rejected draws are retried up to `MAX_TENTATIVAS` times.
- The accepted squares go to the game datapath one at a time over a valid/ack handshake.

Parameters:
- ESPERA_CICLOS, 2, cycles between the falling edge of `novaJogada` and capture of generator outputs (1..15).
- MAX_TENTATIVAS, 8, draws allowed per `iniciar` before reporting an error (1..15).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- iniciar  input  1  start request; sampled only in OCIOSO.
- coluna1_in, linha1_in, coluna2_in, linha2_in, coluna3_in, linha3_in  input  3 each  generator square outputs.
- ack  input  1  datapath has consumed the presented square.
- novaJogada  output  1  draw strobe to the generator; registered, high for exactly 1 cycle.
- coluna  output  3  presented square column.
- linha  output  3  presented square row.
- indice  output  2  presented square index: 0, 1, 2.
- valido  output  1  coluna/linha/indice are valid.
- pronto  output  1  all three squares delivered; held until the next `iniciar`.
- erro  output  1  `MAX_TENTATIVAS` exhausted; held until the next `iniciar`.
- tentativas  output  4  draws used in the current run.

Behaviour:
Reset (reset=0, asynchronous): all outputs go to 0 and the state goes to OCIOSO. Internal square registers, the wait counter and the index are cleared. Reset mid-run aborts immediately; no pending `novaJogada` or `valido` survives.

State machine (registered, one transition per clock):
- OCIOSO:
  - `pronto`/`erro` hold their last value.
  - iniciar=1 -> GERA. On this transition: clear `pronto`, `erro` and `tentativas`.
- GERA: `novaJogada`=1 for this cycle only; `tentativas` += 1. Next state ESPERA, with the wait counter loaded to 0.
- ESPERA: `novaJogada`=0. Counter increments each cycle; on reaching ESPERA_CICLOS-1 -> CAPTURA. Total dwell is exactly ESPERA_CICLOS cycles.
- CAPTURA: register all six inputs as squares s0, s1, s2 (s = {coluna, linha}, 6 bits). -> VERIFICA.
- VERIFICA: compare the registered squares only; the datapath inputs are not re-read here.
  - If s0==s1, s0==s2 or s1==s2, the draw is rejected:
    - tentativas==MAX_TENTATIVAS -> ERRO;
    - otherwise -> GERA.
  - Else indice=0 -> APRESENTA.
- APRESENTA:
  - `valido`=1; `coluna`/`linha` = square[indice].
  - ack=1 in a cycle with valido=1 completes the transfer in that cycle:
    - indice==2 -> FIM;
    - otherwise indice += 1 and stay in APRESENTA with `valido` kept at 1, so back-to-back acks deliver one square per cycle.
  - ack=0: outputs hold stable indefinitely.
- FIM: `valido`=0, `pronto`=1. -> OCIOSO next cycle.
- ERRO: `valido`=0, `erro`=1. -> OCIOSO next cycle.

Rules:
- `ack` outside APRESENTA is ignored.
- `iniciar` outside OCIOSO is ignored; it is neither queued nor a restart.
- iniciar and ack arriving together in the same cycle: ack governs (state is APRESENTA), iniciar is ignored.
- `pronto` and `erro` are never high together.
- `tentativas` never exceeds MAX_TENTATIVAS. It saturates at 15 width-wise, but the parameter limit keeps it below that.
- `coluna`/`linha`/`indice` are 0 whenever valido=0.
- Latency from iniciar=1 (OCIOSO) to first valido=1, on a distinct draw: 1 (GERA) + ESPERA_CICLOS + 1 (CAPTURA) + 1 (VERIFICA) + 1 = 6 cycles at the default.
- Each rejected draw adds ESPERA_CICLOS + 3 cycles.

Test Plan:
1. Reset asserted while in APRESENTA with valido=1 -> `valido`, `novaJogada`, `pronto`, `erro` and `tentativas` all 0 without waiting for a clock edge; state OCIOSO after reset release.
2. Generator model returns (3,5),(0,7),(6,2), iniciar pulsed, ack held 1 ->
   - novaJogada high exactly 1 cycle;
   - valido rises 6 cycles after iniciar;
   - indice 0,1,2 on consecutive cycles with coluna/linha 3/5, 0/7, 6/2;
   - pronto=1 next cycle; tentativas=1.
3. First draw (2,2),(2,2),(4,1), second draw (1,0),(2,2),(4,1) -> exactly two `novaJogada` pulses, 5 cycles apart; tentativas=2; squares 1/0, 2/2, 4/1 delivered.
4. Generator always returns identical squares, MAX_TENTATIVAS=8 -> 8 `novaJogada` pulses; erro=1 with tentativas=8; valido never asserted; pronto=0.
5. Valid draw, ack held 0 for 10 cycles then pulsed three times with gaps -> coluna/linha/indice stable while ack=0; one square advanced per ack; pronto only after the third ack.
6. iniciar re-asserted during ESPERA and APRESENTA -> ignored, no extra `novaJogada`. iniciar after pronto=1 -> pronto clears in the GERA cycle and a new run starts with tentativas=1.
